// File: rtl/ball_physics_if.sv
// Ball-physics control/status bus.
// The game controller (master) drives strobes and hit velocities; the
// physics engine (slave) returns ball position, velocity and point events.
interface ball_physics_if;
  logic              tick;
  logic              freeze;
  logic              serve;
  logic              serve_side;
  logic              hit;
  logic signed [5:0] hit_vx;
  logic signed [5:0] hit_vy;
  logic        [9:0] ball_x;
  logic        [9:0] ball_y;
  logic signed [5:0] ball_vx;
  logic signed [5:0] ball_vy;
  logic              in_play;
  logic              point_valid;
  logic              point_side;

  modport master (
    output tick, freeze, serve, serve_side, hit, hit_vx, hit_vy,
    input  ball_x, ball_y, ball_vx, ball_vy, in_play, point_valid, point_side
  );

  modport slave (
    input  tick, freeze, serve, serve_side, hit, hit_vx, hit_vy,
    output ball_x, ball_y, ball_vx, ball_vy, in_play, point_valid, point_side
  );
endinterface

// File: rtl/ball_physics.sv
// Ball motion engine: position/velocity state, gravity, wall/ceiling/net
// bounces, player-hit velocity loads and ground-contact point events.
// Optional feature macro: BALL_PHYS_NET_EN (net collision). When it is not
// defined the ball passes straight through the net region.
module ball_physics #(
  parameter int SCREEN_W   = 640,
  parameter int BALL_SIZE  = 40,
  parameter int GROUND_Y   = 440,
  parameter int NET_X      = 316,
  parameter int NET_W      = 8,
  parameter int NET_TOP    = 300,
  parameter int GRAVITY    = 1,
  parameter int MAX_VY     = 15,
  parameter int SERVE_XL   = 56,
  parameter int SERVE_XR   = 544,
  parameter int SERVE_Y    = 100,
  parameter int HOLD_TICKS = 60
) (
  input  logic clk,
  input  logic rst,
  ball_physics_if.slave bus
);

  typedef logic signed [10:0] s11_t;
  typedef enum logic [1:0] {IDLE, FLIGHT, SCORED} state_t;

  localparam int HW = $clog2(HOLD_TICKS + 1);

  // Physics arithmetic constants, all in the 11-bit signed domain.
  localparam s11_t XMAX  = s11_t'(SCREEN_W - BALL_SIZE);
  localparam s11_t YGND  = s11_t'(GROUND_Y - BALL_SIZE);
  localparam s11_t GRAV  = s11_t'(GRAVITY);
  localparam s11_t VYCAP = s11_t'(MAX_VY);
  localparam s11_t HALF  = s11_t'(BALL_SIZE / 2);
  localparam s11_t NET_C = s11_t'(NET_X + NET_W / 2);

  // Register-domain position constants.
  localparam logic [9:0] XMAX10 = 10'(SCREEN_W - BALL_SIZE);
  localparam logic [9:0] YGND10 = 10'(GROUND_Y - BALL_SIZE);
  localparam logic [9:0] SXL10  = 10'(SERVE_XL);
  localparam logic [9:0] SXR10  = 10'(SERVE_XR);
  localparam logic [9:0] SY10   = 10'(SERVE_Y);

`ifdef BALL_PHYS_NET_EN
  localparam s11_t       NET_L   = s11_t'(NET_X);
  localparam s11_t       NET_R   = s11_t'(NET_X + NET_W);
  localparam s11_t       NET_T   = s11_t'(NET_TOP);
  localparam s11_t       BSZ     = s11_t'(BALL_SIZE);
  localparam logic [9:0] NFLUSHL = 10'(NET_X - BALL_SIZE);
  localparam logic [9:0] NFLUSHR = 10'(NET_X + NET_W);
`else
  // Net height only matters for collisions, which are not built here.
  logic [31:0] net_top_unused;
  assign net_top_unused = 32'(NET_TOP);
`endif

  state_t            state_q;
  logic        [9:0] x_q, y_q;
  logic signed [5:0] vx_q, vy_q;
  logic              in_play_q, point_valid_q, point_side_q;
  logic     [HW-1:0] hold_q;

  // Results of one physics tick from the current state.
  logic        [9:0] x_d, y_d;
  logic signed [5:0] vx_d, vy_d;
  logic              land_d, side_d;
  s11_t              vy_n, x_n, y_n;

  // Negation that keeps -32 in range by saturating to +31.
  function automatic logic signed [5:0] neg_sat(input logic signed [5:0] v);
    return (v == 6'sb100000) ? 6'sd31 : -v;
  endfunction

  // One physics update: gravity, walls, ceiling, optional net, then ground.
  always_comb begin
    vy_n = s11_t'(vy_q) + GRAV;
    if (vy_n > VYCAP) vy_n = VYCAP;
    x_n  = $signed({1'b0, x_q}) + s11_t'(vx_q);
    y_n  = $signed({1'b0, y_q}) + vy_n;

    x_d    = x_n[9:0];
    y_d    = y_n[9:0];
    vx_d   = vx_q;
    vy_d   = vy_n[5:0];
    land_d = 1'b0;

    if (x_n[10]) begin
      x_d  = '0;
      vx_d = neg_sat(vx_q);
    end else if (x_n > XMAX) begin
      x_d  = XMAX10;
      vx_d = neg_sat(vx_q);
    end

    if (y_n[10]) begin
      y_d  = '0;
      vy_d = 6'(-vy_n);
    end

`ifdef BALL_PHYS_NET_EN
    // Bounce off the net and sit flush on whichever side the ball came from.
    if ((x_n < NET_R) && (x_n + BSZ > NET_L) && (y_n + BSZ > NET_T)) begin
      vx_d = neg_sat(vx_q);
      x_d  = (($signed({1'b0, x_q}) + HALF) < NET_C) ? NFLUSHL : NFLUSHR;
    end
`endif

    if (y_n >= YGND) begin
      y_d    = YGND10;
      vx_d   = '0;
      vy_d   = '0;
      land_d = 1'b1;
    end

    // Landing half is judged from where the ball comes to rest.
    side_d = ($signed({1'b0, x_d}) + HALF) >= NET_C;
  end

  // Game FSM with registered ball state and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      x_q           <= SXL10;
      y_q           <= SY10;
      vx_q          <= '0;
      vy_q          <= '0;
      in_play_q     <= 1'b0;
      point_valid_q <= 1'b0;
      point_side_q  <= 1'b0;
      hold_q        <= '0;
    end else begin
      // The point event is a pulse even if freeze arrives right after it.
      point_valid_q <= 1'b0;
      if (!bus.freeze) begin
        case (state_q)
          IDLE: begin
            if (bus.serve) begin
              x_q       <= bus.serve_side ? SXR10 : SXL10;
              y_q       <= SY10;
              vx_q      <= '0;
              vy_q      <= '0;
              in_play_q <= 1'b1;
              state_q   <= FLIGHT;
            end
          end
          FLIGHT: begin
            if (bus.hit) begin
              vx_q <= bus.hit_vx;
              vy_q <= bus.hit_vy;
            end else if (bus.tick) begin
              x_q  <= x_d;
              y_q  <= y_d;
              vx_q <= vx_d;
              vy_q <= vy_d;
              if (land_d) begin
                state_q       <= SCORED;
                in_play_q     <= 1'b0;
                point_valid_q <= 1'b1;
                point_side_q  <= side_d;
                hold_q        <= '0;
              end
            end
          end
          SCORED: begin
            if (bus.tick) begin
              if (hold_q == HW'(HOLD_TICKS - 1)) begin
                hold_q  <= '0;
                state_q <= IDLE;
                // Next serve goes to the side that did not take the landing.
                x_q     <= point_side_q ? SXL10 : SXR10;
                y_q     <= SY10;
                vx_q    <= '0;
                vy_q    <= '0;
              end else begin
                hold_q <= hold_q + HW'(1);
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.ball_x      = x_q;
  assign bus.ball_y      = y_q;
  assign bus.ball_vx     = vx_q;
  assign bus.ball_vy     = vy_q;
  assign bus.in_play     = in_play_q;
  assign bus.point_valid = point_valid_q;
  assign bus.point_side  = point_side_q;

endmodule

// File: tb/tb_ball_physics.sv
// Bench for ball_physics: directed scenarios with literal expectations plus
// random stimulus, all checked every cycle against a reference model.
module tb_ball_physics;

  localparam int XL = 56, XR = 544, SY = 100, GY = 400, XMAX = 600, HOLD = 60;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ball_physics_if bus();
  ball_physics dut (.clk(clk), .rst(rst), .bus(bus.slave));

  int errs = 0, checks = 0;
  bit check_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: game state as plain integers (0 idle, 1 flight, 2 scored).
  int m_st = 0, m_x = XL, m_y = SY, m_vx = 0, m_vy = 0, m_hold = 0;
  bit m_pv = 0, m_ps = 0;

  function automatic int negs(input int v);
    return (v == -32) ? 31 : -v;
  endfunction

  task automatic model_step();
    int vy2, x2, y2, nx, ny, nvx, nvy;
    m_pv = 0;
    if (rst) begin
      m_st = 0; m_x = XL; m_y = SY; m_vx = 0; m_vy = 0; m_hold = 0; m_ps = 0;
    end else if (!bus.freeze) begin
      if (m_st == 0) begin
        if (bus.serve) begin
          m_x = bus.serve_side ? XR : XL; m_y = SY; m_vx = 0; m_vy = 0; m_st = 1;
        end
      end else if (m_st == 1) begin
        if (bus.hit) begin
          m_vx = $signed(bus.hit_vx); m_vy = $signed(bus.hit_vy);
        end else if (bus.tick) begin
          vy2 = (m_vy + 1 > 15) ? 15 : m_vy + 1;
          x2 = m_x + m_vx; y2 = m_y + vy2;
          nx = x2; ny = y2; nvx = m_vx; nvy = vy2;
          if (x2 < 0) begin nx = 0; nvx = negs(m_vx); end
          else if (x2 > XMAX) begin nx = XMAX; nvx = negs(m_vx); end
          if (y2 < 0) begin ny = 0; nvy = -vy2; end
`ifdef BALL_PHYS_NET_EN
          if (x2 < 324 && x2 + 40 > 316 && y2 + 40 > 300) begin
            nvx = negs(m_vx);
            nx = (m_x + 20 < 320) ? 276 : 324;
          end
`endif
          if (y2 >= GY) begin
            ny = GY; nvx = 0; nvy = 0;
            m_pv = 1; m_ps = (nx + 20 >= 320); m_st = 2; m_hold = 0;
          end
          m_x = nx; m_y = ny; m_vx = nvx; m_vy = nvy;
        end
      end else begin
        if (bus.tick) begin
          m_hold++;
          if (m_hold == HOLD) begin
            m_hold = 0; m_st = 0; m_x = m_ps ? XL : XR; m_y = SY; m_vx = 0; m_vy = 0;
          end
        end
      end
    end
  endtask

  always @(posedge clk) model_step();

  // Every-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    if (check_en) begin
      chk("x", int'(bus.ball_x), m_x);
      chk("y", int'(bus.ball_y), m_y);
      chk("vx", int'($signed(bus.ball_vx)), m_vx);
      chk("vy", int'($signed(bus.ball_vy)), m_vy);
      chk("in_play", int'(bus.in_play), int'(m_st == 1));
      chk("point_valid", int'(bus.point_valid), int'(m_pv));
      if (m_pv) chk("point_side", int'(bus.point_side), int'(m_ps));
    end
  end

  int pv_cnt = 0;
  always @(negedge clk) if (bus.point_valid === 1'b1) pv_cnt++;

  task automatic drive(input bit r, t, f, s, sd, h, input int hvx, hvy);
    @(negedge clk);
    rst = r; bus.tick = t; bus.freeze = f; bus.serve = s; bus.serve_side = sd;
    bus.hit = h; bus.hit_vx = 6'(hvx); bus.hit_vy = 6'(hvy);
  endtask
  task automatic nop();                drive(0, 0, 0, 0, 0, 0, 0, 0);   endtask
  task automatic tick1();              drive(0, 1, 0, 0, 0, 0, 0, 0); nop(); endtask
  task automatic do_reset();           drive(1, 0, 0, 0, 0, 0, 0, 0); nop(); endtask
  task automatic do_serve(input bit sd); drive(0, 0, 0, 1, sd, 0, 0, 0); nop(); endtask
  task automatic do_hit(input int vx, vy); drive(0, 0, 0, 0, 0, 1, vx, vy); nop(); endtask

  int g;
  bit t;

  initial begin
    bus.tick = 0; bus.freeze = 0; bus.serve = 0; bus.serve_side = 0;
    bus.hit = 0; bus.hit_vx = 0; bus.hit_vy = 0;
    do_reset();
    check_en = 1'b1;
    chk("rst_x", int'(bus.ball_x), 56);
    chk("rst_y", int'(bus.ball_y), 100);
    chk("rst_inplay", int'(bus.in_play), 0);

    // Serve left then three gravity ticks.
    do_serve(0);
    chk("serve_inplay", int'(bus.in_play), 1);
    repeat (3) tick1();
    chk("fall3_x", int'(bus.ball_x), 56);
    chk("fall3_y", int'(bus.ball_y), 106);
    chk("fall3_vy", int'($signed(bus.ball_vy)), 3);

    // Left wall bounce.
    do_reset(); do_serve(0); do_hit(-10, 0);
    repeat (6) tick1();
    chk("wall_x", int'(bus.ball_x), 0);
    chk("wall_vx", int'($signed(bus.ball_vx)), 10);
    chk("wall_y", int'(bus.ball_y), 121);

    // Saturating reflection of -32.
    do_reset(); do_serve(0); do_hit(-32, 0);
    repeat (2) tick1();
    chk("sat_x", int'(bus.ball_x), 0);
    chk("sat_vx", int'($signed(bus.ball_vx)), 31);

    // Net crossing: tick 23 moves from x=276 toward x=286 at y=340.
    do_reset(); do_serve(0); do_hit(10, 0);
    repeat (23) tick1();
    chk("net_y", int'(bus.ball_y), 340);
`ifdef BALL_PHYS_NET_EN
    chk("net_x", int'(bus.ball_x), 276);
    chk("net_vx", int'($signed(bus.ball_vx)), -10);
`else
    chk("net_x", int'(bus.ball_x), 286);
    chk("net_vx", int'($signed(bus.ball_vx)), 10);
`endif

    // Hit and tick together: velocity loads, position stays.
    drive(0, 1, 0, 0, 0, 1, 5, -3); nop();
    chk("hitwin_y", int'(bus.ball_y), 340);
    chk("hitwin_vx", int'($signed(bus.ball_vx)), 5);
    chk("hitwin_vy", int'($signed(bus.ball_vy)), -3);

    // Freeze holds everything through ticks and a hit.
    repeat (10) begin drive(0, 1, 1, 0, 0, 0, 0, 0); drive(0, 0, 1, 0, 0, 0, 0, 0); end
    drive(0, 0, 1, 0, 0, 1, 20, 20); drive(0, 0, 1, 0, 0, 0, 0, 0); nop();
    chk("frz_y", int'(bus.ball_y), 340);
    chk("frz_vx", int'($signed(bus.ball_vx)), 5);
    chk("frz_vy", int'($signed(bus.ball_vy)), -3);

    // Reset mid-flight.
    do_reset();
    chk("midrst_x", int'(bus.ball_x), 56);
    chk("midrst_y", int'(bus.ball_y), 100);
    chk("midrst_inplay", int'(bus.in_play), 0);

    // Free fall to the ground, hold, return to IDLE on the far side.
    do_serve(0);
    pv_cnt = 0;
    repeat (27) tick1();
    chk("land_y", int'(bus.ball_y), 400);
    chk("land_inplay", int'(bus.in_play), 0);
    repeat (3) nop();
    chk("land_pvcnt", pv_cnt, 1);
    repeat (59) tick1();
    chk("hold59_y", int'(bus.ball_y), 400);
    tick1();
    chk("idle_x", int'(bus.ball_x), 544);
    chk("idle_y", int'(bus.ball_y), 100);

    // Random phase, model-checked every cycle.
    g = 1;
    for (int i = 0; i < 4000; i++) begin
      t = (g >= 1) && ($urandom_range(0, 1) == 1);
      g = t ? 0 : g + 1;
      drive(($urandom_range(0, 699) == 0), t, ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 14) == 0), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 24) == 0), int'($urandom_range(0, 63)),
            int'($urandom_range(0, 63)));
    end
    nop(); nop();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/ball_physics.md
# ball_physics

Ball motion engine for the volleyball game, upstream of the sprite address generator: it owns the ball's position and velocity, applies gravity, and resolves bounces against walls, ceiling and net. It also accepts player-hit velocity loads and detects ground contact, producing a one-cycle point event for the score logic. Outputs `ball_x`/`ball_y` drive the renderer directly.

## Interface
- `SCREEN_W`, 640, playfield width in pixels
- `BALL_SIZE`, 40, ball sprite edge in pixels (square)
- `GROUND_Y`, 440, y of floor surface; ball rests at `GROUND_Y-BALL_SIZE`
- `NET_X`, 316, left edge of net; `NET_W`, 8, net width; `NET_TOP`, 300, net top y
- `GRAVITY`, 1, vy increment per tick; `MAX_VY`, 15, downward speed cap
- `SERVE_XL`, 56 / `SERVE_XR`, 544 / `SERVE_Y`, 100, serve positions
- `HOLD_TICKS`, 60, ticks spent in SCORED before returning to IDLE
- `clk` in 1, game clock, rising edge only; one clock, reset is synchronous and active-high
- `rst` in 1, synchronous active-high reset
- `tick` in 1, one-cycle physics update strobe (frame rate)
- `freeze` in 1, pause; level-sensitive
- `serve` in 1, one-cycle serve request; `serve_side` in 1, 0 = left, 1 = right
- `hit` in 1, one-cycle player contact; `hit_vx`, `hit_vy` in 6 each, signed two's-complement velocity to load
- `ball_x`, `ball_y` out 10, top-left ball position, unsigned pixels
- `ball_vx`, `ball_vy` out 6, signed current velocity
- `in_play` out 1, high in FLIGHT
- `point_valid` out 1, one-cycle landing pulse; `point_side` out 1, half where ball landed (0 left, 1 right), valid with `point_valid`

## Operation
- States: IDLE, FLIGHT, SCORED.
- IDLE: ball parked, velocity 0. `serve` (not frozen) → position (`SERVE_XL` or `SERVE_XR` by `serve_side`, `SERVE_Y`), vx = vy = 0, → FLIGHT.
- FLIGHT, `hit` (not frozen) → vx ← `hit_vx`, vy ← `hit_vy`. Position unchanged. `hit` beats `tick` in the same cycle; that tick is dropped.
- FLIGHT, `tick` (no hit, not frozen), evaluated in 11-bit signed internally:
  - vy' = min(vy + `GRAVITY`, `MAX_VY`); x' = x + vx; y' = y + vy'.
  - x' < 0 → x = 0, vx = −vx. x' > `SCREEN_W-BALL_SIZE` → clamp there, vx = −vx.
  - y' < 0 → y = 0, vy = |vy'|.
  - Net check, when compiled in: the ball rect [x', x'+`BALL_SIZE`) overlaps [`NET_X`, `NET_X+NET_W`) and y'+`BALL_SIZE` > `NET_TOP` → vx = −vx, x clamped flush to the net on the side of the pre-tick centre.
  - Walls/net are resolved before the ground check.
  - y' ≥ `GROUND_Y-BALL_SIZE` → y clamped there, vx = vy = 0, `point_valid` pulse, `point_side` = (x + `BALL_SIZE`/2 ≥ `NET_X + NET_W`/2), → SCORED.
- SCORED: counts `HOLD_TICKS` unfrozen ticks, then → IDLE with the ball parked at the serve position of the non-landing side, y = `SERVE_Y`.
- `freeze` high: `tick`, `hit`, `serve` are ignored and all state is held. These pulses are not queued.
- `serve` outside IDLE and `hit` outside FLIGHT are ignored.
- vx negation saturates: −(−32) = +31.

## Timing
- All outputs are registered. Updates are visible the cycle after the triggering strobe.
- `point_valid` is high exactly one cycle, the cycle after the landing tick, coincident with the state becoming SCORED.
- Reset values: state IDLE, `ball_x` = `SERVE_XL`, `ball_y` = `SERVE_Y`, `ball_vx` = `ball_vy` = 0, `in_play` = 0, `point_valid` = 0, `point_side` = 0, hold counter 0.
- `rst` mid-flight or mid-SCORED takes priority over every input that cycle.
- Throughput: one physics update per `tick`. `tick` is required to be ≥ 2 cycles apart.

## Configuration
- `BALL_PHYS_NET_EN` defined: net collision as specified.
- Undefined: the net check is removed and the ball passes through the net region. `NET_*` parameters are unused. Walls, ceiling and ground are unchanged.

## Test plan
- Reset, `serve`=1, `serve_side`=0, then 3 ticks → (x, y) = (56, 106), vy = 3, `in_play`=1.
- After serve, `hit` with vx=−10, vy=0, then 6 ticks → x = 0, vx = +10 on the 6th tick.
- Free fall from serve until the ground → y = 400, `point_valid` one cycle, `point_side`=0, state SCORED; after 60 ticks → IDLE, ball at (544, 100).
- Ball at x=270, y=300 with vx=+10 → the tick that overlaps the net gives x = 276, vx = −10. With the macro undefined, x = 280 and vx unchanged.
- `hit` and `tick` asserted in the same cycle → velocity loaded, position unchanged.
- `freeze`=1 with 10 ticks and a `hit` → all outputs unchanged. `rst` mid-flight → reset values next cycle.
